// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared RAM/cache types and defaults for the cache memory responder
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
  typedef enum logic [1:0] {IDLE, D_ACC, I_ACC} cmr_state_t;
  localparam word_t ERR_WORD_DEFAULT = 32'hBAD1BAD1;
endpackage

// File: rtl/caches_if.sv
// rtl/caches_if.sv - icache/dcache request bus plus the shared RAM port seen by the responder
interface caches_if;
  import cpu_types_pkg::*;
  logic      iREN, dREN, dWEN, iwait, dwait, ramREN, ramWEN;
  word_t     iaddr, iload, daddr, dstore, dload, ramaddr, ramstore, ramload;
  ramstate_t ramstate;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );
  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore,
    input  iwait, iload, dwait, dload
  );
endinterface

// File: rtl/cmr_watchdog.sv
// rtl/cmr_watchdog.sv - per-word stall counter; pulses timeout in the last allowed cycle
module cmr_watchdog #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic CLK,
  input  logic nRST,
  input  logic clr,
  input  logic en,
  output logic timeout
);
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] count;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)    count <= '0;
    else if (clr) count <= '0;
    else if (en)  count <= count + 1'b1;
  end

  assign timeout = en && (count == CW'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/cache_mem_responder.sv
// rtl/cache_mem_responder.sv - arbitrates icache/dcache onto one RAM port with dcache burst lock and watchdog
// CMR_RR_EN: round-robin arbitration in IDLE instead of fixed dcache priority
module cache_mem_responder
  import cpu_types_pkg::*;
#(
  parameter int    TIMEOUT_CYCLES = 64,
  parameter word_t ERR_WORD       = ERR_WORD_DEFAULT
) (
  input  logic      CLK,
  input  logic      nRST,
  caches_if.slave   cif,
  output logic      bus_err
);
  cmr_state_t state;
  logic d_req, active, ram_ok, ram_err, timeout, done, fault;
`ifdef CMR_RR_EN
  logic last_grant_i;
`endif

  assign d_req   = cif.dREN | cif.dWEN;
  assign active  = ((state == D_ACC) && d_req) || (state == I_ACC);
  assign ram_ok  = (cif.ramstate == ACCESS);
  assign ram_err = (cif.ramstate == ERROR);
  assign done    = active && (ram_ok || ram_err || timeout);
  assign fault   = active && (ram_err || (timeout && !ram_ok));

  cmr_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .CLK     (CLK),
    .nRST    (nRST),
    .clr     (!active || done),
    .en      (active),
    .timeout (timeout)
  );

  always_comb begin
    cif.iwait    = 1'b1;
    cif.dwait    = 1'b1;
    cif.iload    = '0;
    cif.dload    = '0;
    cif.ramREN   = 1'b0;
    cif.ramWEN   = 1'b0;
    cif.ramaddr  = '0;
    cif.ramstore = '0;
    case (state)
      D_ACC: begin
        cif.ramWEN   = cif.dWEN;
        cif.ramREN   = cif.dREN & ~cif.dWEN;
        cif.ramaddr  = cif.daddr;
        cif.ramstore = cif.dstore;
        if (done) begin
          cif.dwait = 1'b0;
          cif.dload = fault ? ERR_WORD : (cif.dWEN ? '0 : cif.ramload);
        end
      end
      I_ACC: begin
        cif.ramREN  = 1'b1;
        cif.ramaddr = cif.iaddr;
        if (done) begin
          cif.iwait = 1'b0;
          cif.iload = fault ? ERR_WORD : cif.ramload;
        end
      end
      default: ;
    endcase
  end

  // A completed D word keeps the grant; the next cycle releases it if the request has dropped.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= IDLE;
      bus_err <= 1'b0;
`ifdef CMR_RR_EN
      last_grant_i <= 1'b1;
`endif
    end else begin
      if (fault) bus_err <= 1'b1;
      case (state)
        IDLE: begin
`ifdef CMR_RR_EN
          if (d_req && (!cif.iREN || last_grant_i)) begin
            state        <= D_ACC;
            last_grant_i <= 1'b0;
          end else if (cif.iREN) begin
            state        <= I_ACC;
            last_grant_i <= 1'b1;
          end
`else
          if (d_req)         state <= D_ACC;
          else if (cif.iREN) state <= I_ACC;
`endif
        end
        D_ACC:   if (!d_req) state <= IDLE;
        I_ACC:   if (done)   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_mem_responder.sv
// tb/tb_cache_mem_responder.sv - directed vector bench for cache_mem_responder
module tb_cache_mem_responder;
  import cpu_types_pkg::*;

  typedef struct {
    logic      iren, dren, dwen;
    word_t     iaddr, daddr, dstore;
    ramstate_t rs;
    word_t     rload;
    logic      iwait, dwait;
    word_t     iload, dload;
    logic      rren, rwen;
    word_t     raddr, rstore;
    logic      berr;
  } vec_t;

  logic CLK = 1'b0;
  logic nRST;
  logic bus_err;
  int   tests = 0;
  int   fails = 0;
  vec_t tv[$];

  caches_if cif ();

  cache_mem_responder #(.TIMEOUT_CYCLES(8)) dut (
    .CLK     (CLK),
    .nRST    (nRST),
    .cif     (cif),
    .bus_err (bus_err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic vec_t v(input logic ir, dr, dw, input word_t ia, da, ds, input ramstate_t rs,
                             input word_t rl, input logic iw, dwt, input word_t il, dl,
                             input logic rr, rw, input word_t ra, rst, input logic be);
    vec_t t;
    t.iren = ir; t.dren = dr; t.dwen = dw; t.iaddr = ia; t.daddr = da; t.dstore = ds;
    t.rs = rs; t.rload = rl; t.iwait = iw; t.dwait = dwt; t.iload = il; t.dload = dl;
    t.rren = rr; t.rwen = rw; t.raddr = ra; t.rstore = rst; t.berr = be;
    return t;
  endfunction

  task automatic drive(input logic ir, dr, dw, input word_t ia, da, ds, input ramstate_t rs, input word_t rl);
    cif.iREN = ir; cif.dREN = dr; cif.dWEN = dw; cif.iaddr = ia; cif.daddr = da;
    cif.dstore = ds; cif.ramstate = rs; cif.ramload = rl;
  endtask

  initial begin
    int done_at;
    word_t ld;
    logic be_at;

    nRST = 1'b0;
    drive(0, 0, 0, 0, 0, 0, FREE, 0);

    // rows: inputs | iwait dwait iload dload ramREN ramWEN ramaddr ramstore bus_err
    tv.push_back(v(0,0,0, 0,0,0, FREE,0,                 1,1, 0,0, 0,0, 0,0, 0));
    tv.push_back(v(0,1,0, 0,32'h100,0, FREE,0,           1,1, 0,0, 0,0, 0,0, 0));
    tv.push_back(v(0,1,0, 0,32'h100,0, BUSY,0,           1,1, 0,0, 1,0, 32'h100,0, 0));
    tv.push_back(v(0,1,0, 0,32'h100,0, BUSY,0,           1,1, 0,0, 1,0, 32'h100,0, 0));
    tv.push_back(v(0,1,0, 0,32'h100,0, ACCESS,32'hCAFE0001, 1,0, 0,32'hCAFE0001, 1,0, 32'h100,0, 0));
    tv.push_back(v(0,0,0, 0,0,0, FREE,0,                 1,1, 0,0, 0,0, 0,0, 0));
    tv.push_back(v(0,0,0, 0,0,0, FREE,0,                 1,1, 0,0, 0,0, 0,0, 0));
    tv.push_back(v(1,0,1, 32'h40,32'h200,5, FREE,0,      1,1, 0,0, 0,0, 0,0, 0));
    tv.push_back(v(1,0,1, 32'h40,32'h200,5, ACCESS,32'h1234, 1,0, 0,0, 0,1, 32'h200,5, 0));
    tv.push_back(v(1,0,0, 32'h40,0,0, FREE,0,            1,1, 0,0, 0,0, 0,0, 0));
    tv.push_back(v(1,0,0, 32'h40,0,0, FREE,0,            1,1, 0,0, 0,0, 0,0, 0));
    tv.push_back(v(1,0,0, 32'h40,0,0, BUSY,0,            1,1, 0,0, 1,0, 32'h40,0, 0));
    tv.push_back(v(1,0,0, 32'h40,0,0, ACCESS,32'h11112222, 0,1, 32'h11112222,0, 1,0, 32'h40,0, 0));
    tv.push_back(v(0,0,0, 0,0,0, FREE,0,                 1,1, 0,0, 0,0, 0,0, 0));
    tv.push_back(v(1,0,1, 32'h80,32'h300,32'hA0, FREE,0, 1,1, 0,0, 0,0, 0,0, 0));
    tv.push_back(v(1,0,1, 32'h80,32'h300,32'hA0, ACCESS,0, 1,0, 0,0, 0,1, 32'h300,32'hA0, 0));
    tv.push_back(v(1,0,1, 32'h80,32'h304,32'hA1, BUSY,0,   1,1, 0,0, 0,1, 32'h304,32'hA1, 0));
    tv.push_back(v(1,0,1, 32'h80,32'h304,32'hA1, ACCESS,0, 1,0, 0,0, 0,1, 32'h304,32'hA1, 0));
    tv.push_back(v(1,1,0, 32'h80,32'h300,0, ACCESS,32'hD0, 1,0, 0,32'hD0, 1,0, 32'h300,0, 0));
    tv.push_back(v(1,1,0, 32'h80,32'h304,0, ACCESS,32'hD1, 1,0, 0,32'hD1, 1,0, 32'h304,0, 0));
    tv.push_back(v(1,0,0, 32'h80,0,0, FREE,0,            1,1, 0,0, 0,0, 0,0, 0));
    tv.push_back(v(1,0,0, 32'h80,0,0, FREE,0,            1,1, 0,0, 0,0, 0,0, 0));
    tv.push_back(v(1,0,0, 32'h80,0,0, ACCESS,32'h77,     0,1, 32'h77,0, 1,0, 32'h80,0, 0));
    tv.push_back(v(1,0,0, 32'h90,0,0, FREE,0,            1,1, 0,0, 0,0, 0,0, 0));
    tv.push_back(v(1,0,0, 32'h90,0,0, ERROR,0,           0,1, 32'hBAD1BAD1,0, 1,0, 32'h90,0, 0));
    tv.push_back(v(1,0,0, 32'h90,0,0, FREE,0,            1,1, 0,0, 0,0, 0,0, 1));
    tv.push_back(v(1,0,0, 32'h90,0,0, ACCESS,32'h55,     0,1, 32'h55,0, 1,0, 32'h90,0, 1));
    tv.push_back(v(0,0,0, 0,0,0, FREE,0,                 1,1, 0,0, 0,0, 0,0, 1));

    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;

    foreach (tv[i]) begin
      @(posedge CLK);
      #1 drive(tv[i].iren, tv[i].dren, tv[i].dwen, tv[i].iaddr, tv[i].daddr, tv[i].dstore, tv[i].rs, tv[i].rload);
      @(negedge CLK);
      chk($sformatf("row%0d.iwait", i),    32'(cif.iwait),    32'(tv[i].iwait));
      chk($sformatf("row%0d.dwait", i),    32'(cif.dwait),    32'(tv[i].dwait));
      chk($sformatf("row%0d.iload", i),    cif.iload,         tv[i].iload);
      chk($sformatf("row%0d.dload", i),    cif.dload,         tv[i].dload);
      chk($sformatf("row%0d.ramREN", i),   32'(cif.ramREN),   32'(tv[i].rren));
      chk($sformatf("row%0d.ramWEN", i),   32'(cif.ramWEN),   32'(tv[i].rwen));
      chk($sformatf("row%0d.ramaddr", i),  cif.ramaddr,       tv[i].raddr);
      chk($sformatf("row%0d.ramstore", i), cif.ramstore,      tv[i].rstore);
      chk($sformatf("row%0d.bus_err", i),  32'(bus_err),      32'(tv[i].berr));
    end

    // async reset in the middle of a D word
    @(posedge CLK);
    #1 drive(0, 1, 0, 0, 32'h500, 0, BUSY, 0);
    @(posedge CLK);
    @(negedge CLK);
    chk("rst.pre_ramREN", 32'(cif.ramREN), 32'd1);
    #2 nRST = 1'b0;
    #1;
    chk("rst.ramREN",  32'(cif.ramREN), 32'd0);
    chk("rst.ramWEN",  32'(cif.ramWEN), 32'd0);
    chk("rst.dwait",   32'(cif.dwait),  32'd1);
    chk("rst.bus_err", 32'(bus_err),    32'd0);
    cif.dREN = 1'b0;
    @(posedge CLK);
    #1 nRST = 1'b1;
    drive(0, 1, 0, 0, 32'h600, 0, ACCESS, 32'h99);
    @(negedge CLK);
    chk("rst.idle_ramREN", 32'(cif.ramREN), 32'd0);
    chk("rst.idle_dwait",  32'(cif.dwait),  32'd1);
    chk("rst.idle_berr",   32'(bus_err),    32'd0);

    // watchdog: RAM stuck BUSY, TIMEOUT_CYCLES=8
    cif.ramstate = BUSY;
    done_at = 0;
    ld = '0;
    be_at = 1'b1;
    for (int g = 1; g <= 20; g++) begin
      @(negedge CLK);
      if (!cif.dwait) begin
        done_at = g;
        ld = cif.dload;
        be_at = bus_err;
        break;
      end
    end
    chk("wd.cycle",     32'(done_at), 32'd8);
    chk("wd.dload",     ld,           32'hBAD1BAD1);
    chk("wd.berr_same", 32'(be_at),   32'd0);
    @(posedge CLK);
    #1 cif.dREN = 1'b0;
    @(negedge CLK);
    chk("wd.bus_err", 32'(bus_err), 32'd1);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("wd.bus_err_sticky", 32'(bus_err), 32'd1);
    chk("wd.idle_dwait",     32'(cif.dwait), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
